// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: shared types and widths for the UART transmit arbiter.
// Holds the FSM state encoding, the byte width and the owner-index width.
package uart_tx_arb_pkg;

  localparam int BYTE_W = 8;
  localparam int OWN_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2
  } arb_st_e;

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker.
// req_i/ptr_i in; vld_o = any request, idx_o = first set bit at or above ptr_i (wrapping).
module uart_rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [OWN_W-1:0] ptr_i,
  output logic             vld_o,
  output logic [OWN_W-1:0] idx_o
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [OWN_W-1:0]  off;
  logic [OWN_W:0]    sum;

  // Rotate so the pointer position lands on bit 0.
  assign dbl = {req_i, req_i};
  assign rot = NREQ'(dbl >> ptr_i);

  // Descending scan: the lowest set offset is written last.
  always_comb begin
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = OWN_W'(k);
    end
  end

  assign vld_o = |req_i;
  assign sum   = {1'b0, ptr_i} + {1'b0, off};
  assign idx_o = (sum >= (OWN_W+1)'(NREQ))
               ? OWN_W'(sum - (OWN_W+1)'(NREQ))
               : sum[OWN_W-1:0];

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one uart_tx between NREQ producers.
// In: clk, reset (async, low), req, req_data, req_last, tx_busy, tx_end.
// Out: ack, tx_start, tx_data, owner, locked, lock_abort (all registered).
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int HOLD_TO = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [BYTE_W*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        ack,
  output logic                   tx_start,
  output logic [BYTE_W-1:0]      tx_data,
  input  logic                   tx_busy,
  input  logic                   tx_end,
  output logic [OWN_W-1:0]       owner,
  output logic                   locked,
  output logic                   lock_abort
);

  localparam logic [15:0] CNT_MAX = 16'(HOLD_TO - 1);

  arb_st_e            state_q;
  logic [OWN_W-1:0]   ptr_q;
  logic [OWN_W-1:0]   ptr_d;
  logic [OWN_W-1:0]   owner_q;
  logic [15:0]        cnt_q;
  logic               last_q;
  logic               locked_q;
  logic               abort_q;
  logic               start_q;
  logic [NREQ-1:0]    ack_q;
  logic [BYTE_W-1:0]  data_q;

  logic               pick_vld;
  logic [OWN_W-1:0]   pick_idx;
  logic [NREQ-1:0]    pick_oh;
  logic [BYTE_W-1:0]  pick_data;
  logic               pick_last;
  logic [NREQ-1:0]    own_oh;
  logic [BYTE_W-1:0]  own_data;
  logic               own_last;
  logic               own_req;

  uart_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .vld_o (pick_vld),
    .idx_o (pick_idx)
  );

  // Mux out the winner's and the owner's byte without wide index math.
  always_comb begin
    pick_oh   = '0;
    pick_data = '0;
    pick_last = 1'b0;
    own_oh    = '0;
    own_data  = '0;
    own_last  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == OWN_W'(i)) begin
        pick_oh[i] = 1'b1;
        pick_data  = req_data[BYTE_W*i +: BYTE_W];
        pick_last  = req_last[i];
      end
      if (owner_q == OWN_W'(i)) begin
        own_oh[i] = 1'b1;
        own_data  = req_data[BYTE_W*i +: BYTE_W];
        own_last  = req_last[i];
      end
    end
  end

  assign own_req = |(req & own_oh);
  assign ptr_d   = (owner_q == OWN_W'(NREQ - 1))
                 ? '0 : owner_q + OWN_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      locked_q <= 1'b0;
      abort_q  <= 1'b0;
      start_q  <= 1'b0;
      ack_q    <= '0;
      data_q   <= '0;
    end else begin
      start_q <= 1'b0;
      ack_q   <= '0;
      abort_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!tx_busy && pick_vld) begin
            data_q  <= pick_data;
            owner_q <= pick_idx;
            last_q  <= pick_last;
            start_q <= 1'b1;
            ack_q   <= pick_oh;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_end) begin
            if (last_q) begin
              ptr_q    <= ptr_d;
              locked_q <= 1'b0;
              state_q  <= ST_IDLE;
            end else begin
              locked_q <= 1'b1;
              cnt_q    <= '0;
              state_q  <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          // A request in the expiry cycle still wins over the abort.
          if (own_req) begin
            data_q  <= own_data;
            last_q  <= own_last;
            start_q <= 1'b1;
            ack_q   <= own_oh;
            cnt_q   <= '0;
            state_q <= ST_SEND;
          end else if (cnt_q == CNT_MAX) begin
            abort_q  <= 1'b1;
            locked_q <= 1'b0;
            ptr_q    <= ptr_d;
            state_q  <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack        = ack_q;
  assign tx_start   = start_q;
  assign tx_data    = data_q;
  assign owner      = owner_q;
  assign locked     = locked_q;
  assign lock_abort = abort_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed self-checking bench for uart_tx_arb.
// A small serializer model answers tx_start with busy and a tx_end pulse.
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_end;
  logic [1:0]  owner;
  logic        locked;
  logic        lock_abort;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int rem    = 0;

  bit [7:0] log_d[$];
  bit [1:0] log_o[$];
  int       log_c[$];
  int       end_c[$];

  uart_tx_arb #(
    .NREQ    (2),
    .HOLD_TO (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .req_last   (req_last),
    .ack        (ack),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .tx_end     (tx_end),
    .owner      (owner),
    .locked     (locked),
    .lock_abort (lock_abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Serializer: busy for 3 cycles after tx_start, then tx_end with busy low.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      tx_end = 1'b0;
      if (!reset) begin
        rem     = 0;
        tx_busy = 1'b0;
      end else if (tx_start) begin
        chk("start_not_busy", tx_busy, 0);
        chk("ack_onehot", $onehot(ack), 1);
        log_d.push_back(tx_data);
        log_o.push_back(owner);
        log_c.push_back(cyc);
        tx_busy = 1'b1;
        rem     = 3;
      end else if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          tx_end  = 1'b1;
          tx_busy = 1'b0;
          end_c.push_back(cyc);
        end
      end
    end
  end

  task automatic do_reset();
    reset    = 1'b0;
    req      = '0;
    req_last = '0;
    repeat (2) @(negedge clk);
    log_d.delete();
    log_o.delete();
    log_c.delete();
    end_c.delete();
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_ack(input logic [1:0] m, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if ((ack & m) != 2'b00) ok = 1'b1;
    end
    chk(tag, ok, 1);
  endtask

  task automatic wait_end(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (tx_end) ok = 1'b1;
    end
    chk(tag, ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit seen;
    reset    = 1'b0;
    req      = '0;
    req_last = '0;
    req_data = '0;
    tx_busy  = 1'b0;
    tx_end   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_owner", owner, 0);
    chk("rst_locked", locked, 0);
    chk("rst_abort", lock_abort, 0);

    // Single byte, then pointer moves to 1.
    do_reset();
    req_data[7:0] = 8'hA5;
    req_last      = 2'b01;
    req           = 2'b01;
    @(negedge clk);
    chk("t1_start", tx_start, 1);
    chk("t1_ack", ack, 2'b01);
    chk("t1_data", tx_data, 8'hA5);
    chk("t1_owner", owner, 0);
    req = 2'b00;
    wait_end("t1_end");
    @(negedge clk);
    chk("t1_unlocked", locked, 0);
    req_data[15:8] = 8'hB6;
    req_last       = 2'b11;
    req            = 2'b11;
    @(negedge clk);
    chk("t1_ptr_start", tx_start, 1);
    chk("t1_ptr_owner", owner, 1);
    chk("t1_ptr_ack", ack, 2'b10);
    chk("t1_ptr_data", tx_data, 8'hB6);
    req = 2'b00;
    wait_end("t1_end2");

    // Fairness with both requesters held.
    do_reset();
    req_data = {8'h31, 8'h20};
    req_last = 2'b11;
    req      = 2'b11;
    for (int i = 0; i < 100 && log_d.size() < 4; i++) @(negedge clk);
    req = 2'b00;
    chk("t2_count", (log_d.size() >= 4), 1);
    chk("t2_o0", log_o[0], 0);
    chk("t2_o1", log_o[1], 1);
    chk("t2_o2", log_o[2], 0);
    chk("t2_o3", log_o[3], 1);
    chk("t2_d1", log_d[1], 8'h31);
    chk("t2_d2", log_d[2], 8'h20);
    chk("t2_gap", log_c[1] - end_c[0], 2);
    wait_end("t2_end");

    // Locked two-byte message from requester 1.
    do_reset();
    req_data[15:8] = 8'h10;
    req_last       = 2'b00;
    req            = 2'b10;
    wait_ack(2'b10, "t3_ack1");
    req_data = {8'h11, 8'h55};
    req_last = 2'b11;
    req      = 2'b11;
    wait_ack(2'b10, "t3_ack2");
    chk("t3_locked", locked, 1);
    req = 2'b01;
    wait_ack(2'b01, "t3_ack3");
    req = 2'b00;
    wait_end("t3_end");
    chk("t3_d0", log_d[0], 8'h10);
    chk("t3_d1", log_d[1], 8'h11);
    chk("t3_d2", log_d[2], 8'h55);
    chk("t3_gap", log_c[1] - end_c[0], 2);

    // Hold timeout, then requester 1 wins.
    do_reset();
    req_data[7:0] = 8'h77;
    req_last      = 2'b00;
    req           = 2'b01;
    wait_ack(2'b01, "t4_ack");
    req = 2'b00;
    wait_end("t4_end");
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (k == 1) chk("t4_locked", locked, 1);
      if (lock_abort) seen = 1'b1;
    end
    chk("t4_abort_at", k, 9);
    chk("t4_unlock", locked, 0);
    req_data[15:8] = 8'h88;
    req_last       = 2'b11;
    req            = 2'b11;
    @(negedge clk);
    chk("t4_start", tx_start, 1);
    chk("t4_owner", owner, 1);
    chk("t4_ack", ack, 2'b10);
    chk("t4_data", tx_data, 8'h88);
    req = 2'b00;
    wait_end("t4_end2");

    // Request in the expiry cycle beats the abort.
    do_reset();
    req_data[7:0] = 8'h40;
    req_last      = 2'b00;
    req           = 2'b01;
    wait_ack(2'b01, "t5_ack");
    req = 2'b00;
    wait_end("t5_end");
    repeat (8) @(negedge clk);
    req_data[7:0] = 8'h41;
    req_last      = 2'b01;
    req           = 2'b01;
    @(negedge clk);
    chk("t5_start", tx_start, 1);
    chk("t5_ack", ack, 2'b01);
    chk("t5_noabort", lock_abort, 0);
    chk("t5_data", tx_data, 8'h41);
    req = 2'b00;
    @(negedge clk);
    chk("t5_noabort2", lock_abort, 0);
    wait_end("t5_end2");

    // Reset while the serializer is busy.
    do_reset();
    req_data[15:8] = 8'h66;
    req_last       = 2'b00;
    req            = 2'b10;
    wait_ack(2'b10, "t6_ack");
    chk("t6_owner_pre", owner, 1);
    reset = 1'b0;
    #1;
    chk("t6_start", tx_start, 0);
    chk("t6_ackclr", ack, 0);
    chk("t6_owner", owner, 0);
    chk("t6_locked", locked, 0);
    chk("t6_data", tx_data, 0);
    req = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    req_data[15:8] = 8'h67;
    req_last       = 2'b10;
    req            = 2'b10;
    wait_ack(2'b10, "t6_ack2");
    chk("t6_data2", tx_data, 8'h67);
    chk("t6_owner2", owner, 1);
    req = 2'b00;
    wait_end("t6_end");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
